// File: rtl/imem_boot_loader.sv
// Boot loader: packs a length-prefixed byte stream into 32-bit little-endian words,
// writes them to instruction memory and holds the core in reset until the image is complete.
module imem_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Handshake: a byte moves on a rising edge where byte_valid and byte_ready are
  // both 1. byte_ready depends on state only, never on byte_valid.

  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int WIDX_W = $clog2(MAX_WORDS + 1);
  localparam logic [15:0]      MAX_N    = 16'(MAX_WORDS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_RUN   = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t state, state_nxt;

  logic [15:0]       count;
  logic [WIDX_W-1:0] word_idx;
  logic [1:0]        byte_idx;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [31:0]       word_buf;

  logic        xfer;
  logic        loading;
  logic        restart;
  logic        tmo_expire;
  logic        last_word;
  logic [15:0] n_hdr;
  logic [31:0] word_next;

  assign xfer      = byte_valid & byte_ready;
  assign loading   = (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA);
  assign restart   = start && ((state == S_IDLE) || (state == S_RUN) || (state == S_ERR));
  assign n_hdr     = {byte_data, count[7:0]};
  assign word_next = {byte_data, word_buf[31:8]};
  assign last_word = (16'(word_idx) + 16'd1) == count;

  // A byte arriving on the terminal-count cycle wins over the timeout.
  assign tmo_expire = loading && !xfer && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) state_nxt = S_HDR0;
      end
      S_HDR0: begin
        if (xfer) state_nxt = S_HDR1;
      end
      S_HDR1: begin
        if (xfer) begin
          if (n_hdr == 16'd0)     state_nxt = S_RUN;
          else if (n_hdr > MAX_N) state_nxt = S_ERR;
          else                    state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && (byte_idx == 2'd3)) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        state_nxt = last_word ? S_RUN : S_DATA;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (tmo_expire) state_nxt = S_ERR;
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wd     <= '0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      count      <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      tmo_cnt    <= '0;
      word_buf   <= '0;
    end else begin
      state <= state_nxt;

      // Status outputs are registered copies of the next state.
      byte_ready <= (state_nxt == S_HDR0) || (state_nxt == S_HDR1) || (state_nxt == S_DATA);
      busy       <= (state_nxt == S_HDR0) || (state_nxt == S_HDR1) ||
                    (state_nxt == S_DATA) || (state_nxt == S_WRITE);
      done       <= (state_nxt == S_RUN);
      error      <= (state_nxt == S_ERR);
      core_reset <= (state_nxt != S_RUN);
      mem_we     <= (state_nxt == S_WRITE);

      if (restart) begin
        count    <= '0;
        word_idx <= '0;
        byte_idx <= '0;
        tmo_cnt  <= '0;
        word_buf <= '0;
      end else begin
        if (loading) begin
          if (xfer || tmo_expire) tmo_cnt <= '0;
          else                    tmo_cnt <= tmo_cnt + 1'b1;
        end

        if ((state == S_HDR0) && xfer) count[7:0]  <= byte_data;
        if ((state == S_HDR1) && xfer) count[15:8] <= byte_data;

        if ((state == S_DATA) && xfer) begin
          word_buf <= word_next;
          byte_idx <= byte_idx + 2'd1;
          // The write address and data are captured with the fourth byte.
          if (byte_idx == 2'd3) begin
            mem_addr <= ADDR_W'({word_idx, 2'b00});
            mem_wd   <= word_next;
          end
        end

        if (state == S_WRITE) begin
          byte_idx <= '0;
          if (!last_word) word_idx <= word_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed byte streams drive the loader while a
// forked monitor pops expected {addr, data} writes from a queue.
module tb_imem_boot_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 256;
  localparam int TIMEOUT   = 1024;
  localparam int W         = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              Reset = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic              error;

  int n_asserts = 0;
  int n_fail    = 0;
  int n_writes  = 0;
  int cyc       = 0;

  logic [W-1:0] exp_q[$];

  imem_boot_loader #(
    .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .Reset(Reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .core_reset(core_reset), .busy(busy), .done(done), .error(error)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        n_writes++;
        check("ready_low_in_write", 32'(byte_ready), 32'd0);
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("write_addr", 32'(mem_addr), 32'(e[W-1:32]));
          check("write_data", mem_wd, e[31:0]);
        end
      end
    end
  endtask

  // Driver tasks: all called and returning on a falling edge
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_reset();
    Reset = 1'b0;
    repeat (2) @(negedge clk);
    Reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    int bound;
    for (int i = 0; i < gap; i++) begin
      byte_valid = 1'b0;
      start = poke && (i == 0);
      @(negedge clk);
    end
    start = 1'b0;
    byte_valid = 1'b1;
    byte_data = b;
    bound = 0;
    while (byte_ready !== 1'b1 && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    check("byte_ready_within_bound", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  logic [31:0] prog8 [8] = '{32'h00500013, 32'h00A00093, 32'h002081B3, 32'hDEADBEEF,
                             32'h12345678, 32'h80000001, 32'hFFFFFFFF, 32'h00000000};

  initial begin
    int t0;
    int wr0;
    int bound;
    int gap;
    fork
      monitor();
    join_none

    // Reset state
    Reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    Reset = 1'b1;
    @(negedge clk);
    check("idle_core_reset", 32'(core_reset), 32'd1);

    // Reset mid-DATA after five bytes
    pulse_start();
    send_byte(8'h02, 0, 0); send_byte(8'h00, 0, 0);
    send_byte(8'h13, 0, 0); send_byte(8'h00, 0, 0); send_byte(8'h50, 0, 0);
    check("mid_busy_before_reset", 32'(busy), 32'd1);
    apply_reset();
    check("mid_rst_core_reset", 32'(core_reset), 32'd1);
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_byte_ready", 32'(byte_ready), 32'd0);

    // Two-word program, back to back, reloads from word 0
    wr0 = n_writes;
    exp_q.push_back({10'h000, 32'h00500013});
    exp_q.push_back({10'h004, 32'h00A00093});
    pulse_start();
    t0 = cyc;
    check("prog_busy_after_start", 32'(busy), 32'd1);
    send_byte(8'h02, 0, 0); send_byte(8'h00, 0, 0);
    send_byte(8'h13, 0, 0); send_byte(8'h00, 0, 0); send_byte(8'h50, 0, 0); send_byte(8'h00, 0, 0);
    send_byte(8'h93, 0, 0); send_byte(8'h00, 0, 0); send_byte(8'hA0, 0, 0); send_byte(8'h00, 0, 0);
    check("prog_last_write_core_reset", 32'(core_reset), 32'd1);
    check("prog_last_write_done", 32'(done), 32'd0);
    @(negedge clk);
    check("prog_done", 32'(done), 32'd1);
    check("prog_core_reset_released", 32'(core_reset), 32'd0);
    check("prog_busy_clear", 32'(busy), 32'd0);
    check("prog_load_cycles", 32'(cyc - t0), 32'd12);
    check("prog_write_count", 32'(n_writes - wr0), 32'd2);

    // Empty image, restarted from RUN
    wr0 = n_writes;
    pulse_start();
    check("restart_core_reset", 32'(core_reset), 32'd1);
    check("restart_busy", 32'(busy), 32'd1);
    send_byte(8'h00, 0, 0); send_byte(8'h00, 0, 0);
    check("empty_done", 32'(done), 32'd1);
    check("empty_core_reset", 32'(core_reset), 32'd0);
    @(negedge clk);
    check("empty_no_write", 32'(n_writes - wr0), 32'd0);

    // Oversized image N=257
    pulse_start();
    send_byte(8'h01, 0, 0); send_byte(8'h01, 0, 0);
    check("big_error", 32'(error), 32'd1);
    check("big_core_reset", 32'(core_reset), 32'd1);
    check("big_done", 32'(done), 32'd0);
    check("big_busy", 32'(busy), 32'd0);
    pulse_start();
    check("err_restart_busy", 32'(busy), 32'd1);
    check("err_restart_ready", 32'(byte_ready), 32'd1);
    check("err_restart_error", 32'(error), 32'd0);
    check("big_no_write", 32'(n_writes - wr0), 32'd0);
    apply_reset();

    // Timeout after two data bytes
    wr0 = n_writes;
    pulse_start();
    send_byte(8'h01, 0, 0); send_byte(8'h00, 0, 0);
    send_byte(8'hAA, 0, 0); send_byte(8'hBB, 0, 0);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("tmo_not_yet", 32'(error), 32'd0);
    @(negedge clk);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_core_reset", 32'(core_reset), 32'd1);
    check("tmo_no_write", 32'(n_writes - wr0), 32'd0);

    // Third byte lands on the terminal-count cycle
    pulse_start();
    send_byte(8'h01, 0, 0); send_byte(8'h00, 0, 0);
    send_byte(8'h11, 0, 0); send_byte(8'h22, 0, 0);
    send_byte(8'h33, TIMEOUT - 1, 0);
    check("tmo_edge_no_error", 32'(error), 32'd0);
    check("tmo_edge_busy", 32'(busy), 32'd1);
    exp_q.push_back({10'h000, 32'h44332211});
    send_byte(8'h44, 0, 0);
    @(negedge clk);
    check("tmo_edge_done", 32'(done), 32'd1);

    // Eight words with random valid gaps and stray start pulses
    wr0 = n_writes;
    pulse_start();
    send_byte(8'h08, $urandom_range(0, 1), 0);
    send_byte(8'h00, $urandom_range(0, 1), 0);
    for (int w = 0; w < 8; w++) begin
      exp_q.push_back({ADDR_W'(w * 4), prog8[w]});
      for (int k = 0; k < 4; k++) begin
        bit poke;
        poke = ((w == 2) && (k == 1)) || ((w == 5) && (k == 0)) || ((w == 6) && (k == 3));
        gap = poke ? 1 : int'($urandom_range(0, 1));
        send_byte(prog8[w][8*k +: 8], gap, poke);
      end
    end
    bound = 0;
    while (done !== 1'b1 && bound < 20) begin
      @(negedge clk);
      bound++;
    end
    check("rand_done", 32'(done), 32'd1);
    check("rand_core_reset", 32'(core_reset), 32'd0);
    check("rand_write_count", 32'(n_writes - wr0), 32'd8);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
